// File: rtl/bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : bus_pkg                                                         |
// | Shared types and constants for the system-bus slave.                     |
// |   slv_state_t          responder FSM states                              |
// |   MODE_READ/MODE_WRITE  encoding of sl_mode                              |
// |   SEL_MSB/SEL_LSB       slave-select field within sl_address             |
// |   OFF_W                 default byte-offset width                        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } slv_state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam int SEL_MSB = 13;
  localparam int SEL_LSB = 12;
  localparam int OFF_W   = 4;

endpackage
`default_nettype wire

// File: rtl/bus_slave_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : bus_slave_regfile                                               |
// | 2**ADDR_W x 8 byte array: synchronous write, asynchronous read,          |
// | synchronous active-low clear of every byte.                              |
// | Ports:                                                                   |
// |   clk    in   clock, rising edge                                         |
// |   rst_n  in   synchronous active-low reset, clears all bytes             |
// |   we     in   write enable                                               |
// |   waddr  in   write byte offset                                          |
// |   wdata  in   write byte                                                 |
// |   raddr  in   read byte offset                                           |
// |   rdata  out  combinational read of mem[raddr]                           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module bus_slave_regfile
  import bus_pkg::*;
#(
  parameter int ADDR_W = OFF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/bus_slave_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : bus_slave_mem                                                   |
// | System-bus responder: decodes sl_address, performs one read or write on  |
// | a local byte register file and answers with a one-cycle ready strobe.    |
// | Configuration macro: BUS_SLV_WAIT_EN enables WAIT_CYCLES wait states;    |
// | without it the response follows the request directly.                    |
// | Ports:                                                                   |
// |   clk         in   clock, rising edge                                    |
// |   rst_n       in   synchronous active-low reset                          |
// |   m_valid     in   request valid, held until ready is accepted           |
// |   sl_mode     in   1 = write, 0 = read                                   |
// |   sl_address  in   {2'b0, sel[1:0], 8'bx, offset[3:0]}                   |
// |   sl_wdata    in   write byte                                            |
// |   ready       out  registered response strobe                            |
// |   rdata       out  response byte, held until the next response           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module bus_slave_mem
  import bus_pkg::*;
#(
  parameter logic [1:0] SLAVE_ID    = 2'd0,
  parameter int         ADDR_W      = OFF_W,
  parameter int         WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_valid,
  input  logic        sl_mode,
  input  logic [15:0] sl_address,
  input  logic [7:0]  sl_wdata,
  output logic        ready,
  output logic [7:0]  rdata
);

  slv_state_t        r_state;
  slv_state_t        w_state_nxt;
  logic              r_mode;
  logic [ADDR_W-1:0] r_offset;
  logic              w_hit;
  logic [ADDR_W-1:0] w_offset;
  logic              w_we;
  logic              w_rd_mode;
  logic [ADDR_W-1:0] w_rd_offset;
  logic [7:0]        w_mem_rdata;
  logic              w_addr_unused;

  assign w_hit    = (sl_address[15:14] == 2'b00) &&
                    (sl_address[SEL_MSB:SEL_LSB] == SLAVE_ID);
  assign w_offset = sl_address[ADDR_W-1:0];
  // Bits between the offset and the select field are don't-care.
  assign w_addr_unused = ^sl_address[SEL_LSB-1:ADDR_W];

`ifdef BUS_SLV_WAIT_EN
  localparam int WAIT_EFF = WAIT_CYCLES;
  localparam int CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  // Holds the number of WAIT cycles still to spend after the current one.
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_state_nxt == WAIT) begin
      if (r_state == IDLE) begin
        r_cnt <= CNT_W'(WAIT_CYCLES - 1);
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end
`else
  // Wait states compiled out; the parameter stays for a uniform interface.
  localparam int WAIT_EFF = WAIT_CYCLES * 0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_rd_mode   = r_mode;
    w_rd_offset = r_offset;
    case (r_state)
      IDLE: begin
        // Responding straight from IDLE must use the live request fields.
        w_rd_mode   = sl_mode;
        w_rd_offset = w_offset;
        if (m_valid && w_hit) begin
          w_we        = (sl_mode == MODE_WRITE);
          w_state_nxt = (WAIT_EFF != 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
`ifdef BUS_SLV_WAIT_EN
        if (!m_valid) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = RESP;
        end
`else
        w_state_nxt = IDLE;
`endif
      end
      RESP:    w_state_nxt = DONE;
      // Master still requesting means it missed the strobe: re-issue.
      DONE:    w_state_nxt = m_valid ? RESP : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_mode   <= MODE_READ;
      r_offset <= '0;
      ready    <= 1'b0;
      rdata    <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      ready   <= (w_state_nxt == RESP);
      if ((r_state == IDLE) && m_valid && w_hit) begin
        r_mode   <= sl_mode;
        r_offset <= w_offset;
      end
      // Re-entry from DONE reloads the same byte: the array is untouched
      // between the two strobes.
      if (w_state_nxt == RESP) begin
        rdata <= (w_rd_mode == MODE_WRITE) ? 8'h00 : w_mem_rdata;
      end
    end
  end

  bus_slave_regfile #(
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_we),
    .waddr (w_offset),
    .wdata (sl_wdata),
    .raddr (w_rd_offset),
    .rdata (w_mem_rdata)
  );

endmodule
`default_nettype wire
